// File: rtl/cpu_pipe_pkg.sv
// Shared pipeline control types for the 5-stage core.
// Hazard FSM states and the per-stage write/flush bundle.
package cpu_pipe_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    MD_BUSY  = 2'd2
  } hz_state_t;

  localparam logic [4:0] REG_ZERO = 5'd0;

  typedef struct packed {
    logic pc_write;
    logic if_id_write;
    logic if_id_flush;
    logic id_ex_write;
    logic id_ex_flush;
    logic ex_mem_write;
    logic mem_wb_write;
  } stage_ctrl_t;

  localparam stage_ctrl_t CTRL_RUN  = stage_ctrl_t'(7'b1101011);
  localparam stage_ctrl_t CTRL_HOLD = stage_ctrl_t'(7'b0000000);
  localparam stage_ctrl_t CTRL_MD   = stage_ctrl_t'(7'b0000011);
  localparam stage_ctrl_t CTRL_BR   = stage_ctrl_t'(7'b1111111);
  localparam stage_ctrl_t CTRL_LU   = stage_ctrl_t'(7'b0001111);

endpackage

// File: rtl/hazard_stall_ctrl_load_use.sv
// Load-use comparator: ID source matches a pending load destination.
// Pure combinational so decode checks can reuse it.
module hz_load_use_detect
  import cpu_pipe_pkg::*;
(
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic       id_uses_rt,
  input  logic       id_ex_memread,
  input  logic [4:0] id_ex_rt,
  output logic       hazard
);

  logic rs_hit;
  logic rt_hit;

  assign rs_hit = (id_ex_rt == id_rs);
  assign rt_hit = id_uses_rt && (id_ex_rt == id_rt);
  assign hazard = id_ex_memread && (id_ex_rt != REG_ZERO)
                  && (rs_hit || rt_hit);

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Hazard/stall sequencer: memory freeze, muldiv occupancy,
// branch flush and load-use bubble, plus stall/timeout status.
module hazard_stall_ctrl
  import cpu_pipe_pkg::*;
#(
  parameter int MD_LAT      = 8,
  parameter int MEM_TIMEOUT = 64,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_uses_rt,
  input  logic             id_ex_memread,
  input  logic [4:0]       id_ex_rt,
  input  logic             ex_branch_taken,
  input  logic             ex_muldiv_start,
  input  logic             mem_req,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic             if_id_write,
  output logic             if_id_flush,
  output logic             id_ex_write,
  output logic             id_ex_flush,
  output logic             ex_mem_write,
  output logic             mem_wb_write,
  output logic [CNT_W-1:0] stall_cycles,
  output logic             mem_timeout
);

  localparam int LAT_W  = $clog2(MD_LAT);
  localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);

  hz_state_t         state_q, state_d;
  hz_state_t         ret_q, ret_d;
  logic [LAT_W-1:0]  lat_q, lat_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic [CNT_W-1:0]  stall_q, stall_d;
  logic              to_q, to_d;

  stage_ctrl_t ctrl;
  hz_state_t   eff;
  logic        freeze;
  logic        lu_hazard;

  hz_load_use_detect u_lu (
    .id_rs         (id_rs),
    .id_rt         (id_rt),
    .id_uses_rt    (id_uses_rt),
    .id_ex_memread (id_ex_memread),
    .id_ex_rt      (id_ex_rt),
    .hazard        (lu_hazard)
  );

  assign freeze = mem_req && !mem_ready;
  // On the release cycle of a freeze, behave as the state we return to.
  assign eff = (state_q == MEM_WAIT) ? ret_q : state_q;

  always_comb begin
    state_d = state_q;
    ret_d   = ret_q;
    lat_d   = lat_q;
    wait_d  = '0;
    to_d    = to_q;
    ctrl    = CTRL_RUN;
    if (freeze) begin
      ctrl    = CTRL_HOLD;
      state_d = MEM_WAIT;
      if (state_q != MEM_WAIT) ret_d = state_q;
      wait_d  = (wait_q == WAIT_W'(MEM_TIMEOUT))
                ? wait_q : wait_q + WAIT_W'(1);
      if (wait_q == WAIT_W'(MEM_TIMEOUT - 1)) to_d = 1'b1;
    end else if (eff == MD_BUSY) begin
      ctrl = CTRL_MD;
      if (lat_q == '0) begin
        state_d = RUN;
      end else begin
        state_d = MD_BUSY;
        lat_d   = lat_q - LAT_W'(1);
      end
    end else begin
      state_d = RUN;
      if (ex_muldiv_start) begin
        state_d = MD_BUSY;
        lat_d   = LAT_W'(MD_LAT - 1);
      end
      if (ex_branch_taken) ctrl = CTRL_BR;
      else if (lu_hazard)  ctrl = CTRL_LU;
    end
    stall_d = stall_q;
    if (!ctrl.pc_write && (stall_q != '1)) stall_d = stall_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
      ret_q   <= RUN;
      lat_q   <= '0;
      wait_q  <= '0;
      stall_q <= '0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      ret_q   <= ret_d;
      lat_q   <= lat_d;
      wait_q  <= wait_d;
      stall_q <= stall_d;
      to_q    <= to_d;
    end
  end

  assign pc_write     = ctrl.pc_write;
  assign if_id_write  = ctrl.if_id_write;
  assign if_id_flush  = ctrl.if_id_flush;
  assign id_ex_write  = ctrl.id_ex_write;
  assign id_ex_flush  = ctrl.id_ex_flush;
  assign ex_mem_write = ctrl.ex_mem_write;
  assign mem_wb_write = ctrl.mem_wb_write;
  assign stall_cycles = stall_q;
  assign mem_timeout  = to_q;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Scoreboard bench for hazard_stall_ctrl: driver queues expected
// control bits per cycle, monitor compares at the falling edge.
module tb_hazard_stall_ctrl;

  localparam logic [6:0] E_NORM = 7'b1101011;
  localparam logic [6:0] E_HOLD = 7'b0000000;
  localparam logic [6:0] E_MD   = 7'b0000011;
  localparam logic [6:0] E_BR   = 7'b1111111;
  localparam logic [6:0] E_LU   = 7'b0001111;

  typedef struct packed {
    logic [6:0]  ctrl;
    logic [15:0] cnt;
    logic        to;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [4:0]  id_rs = '0;
  logic [4:0]  id_rt = '0;
  logic        id_uses_rt = 1'b0;
  logic        id_ex_memread = 1'b0;
  logic [4:0]  id_ex_rt = '0;
  logic        ex_branch_taken = 1'b0;
  logic        ex_muldiv_start = 1'b0;
  logic        mem_req = 1'b0;
  logic        mem_ready = 1'b1;
  logic        pc_write, if_id_write, if_id_flush, id_ex_write;
  logic        id_ex_flush, ex_mem_write, mem_wb_write;
  logic [15:0] stall_cycles;
  logic        mem_timeout;

  exp_t        sb[$];
  int          total = 0;
  int          bad = 0;
  logic [15:0] exp_stall = '0;
  logic        exp_to = 1'b0;

  hazard_stall_ctrl dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .id_rs           (id_rs),
    .id_rt           (id_rt),
    .id_uses_rt      (id_uses_rt),
    .id_ex_memread   (id_ex_memread),
    .id_ex_rt        (id_ex_rt),
    .ex_branch_taken (ex_branch_taken),
    .ex_muldiv_start (ex_muldiv_start),
    .mem_req         (mem_req),
    .mem_ready       (mem_ready),
    .pc_write        (pc_write),
    .if_id_write     (if_id_write),
    .if_id_flush     (if_id_flush),
    .id_ex_write     (id_ex_write),
    .id_ex_flush     (id_ex_flush),
    .ex_mem_write    (ex_mem_write),
    .mem_wb_write    (mem_wb_write),
    .stall_cycles    (stall_cycles),
    .mem_timeout     (mem_timeout)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    exp_t e;
    logic [6:0] got;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      got = {pc_write, if_id_write, if_id_flush, id_ex_write,
             id_ex_flush, ex_mem_write, mem_wb_write};
      total++;
      if (got !== e.ctrl) begin
        bad++;
        $display("FAIL ctrl t=%0t got=%b want=%b", $time, got, e.ctrl);
      end
      total++;
      if (stall_cycles !== e.cnt) begin
        bad++;
        $display("FAIL stall_cycles t=%0t got=%0d want=%0d",
                 $time, stall_cycles, e.cnt);
      end
      total++;
      if (mem_timeout !== e.to) begin
        bad++;
        $display("FAIL mem_timeout t=%0t got=%b want=%b",
                 $time, mem_timeout, e.to);
      end
    end
  end

  task automatic step(input logic [4:0] rs, input logic [4:0] rt,
                      input logic urt, input logic mr,
                      input logic [4:0] ert, input logic br,
                      input logic md, input logic mreq,
                      input logic mrdy, input logic [6:0] ectrl);
    @(posedge clk);
    #1;
    id_rs = rs; id_rt = rt; id_uses_rt = urt;
    id_ex_memread = mr; id_ex_rt = ert;
    ex_branch_taken = br; ex_muldiv_start = md;
    mem_req = mreq; mem_ready = mrdy;
    sb.push_back('{ctrl: ectrl, cnt: exp_stall, to: exp_to});
    if (!ectrl[6] && exp_stall != 16'hFFFF) exp_stall = exp_stall + 16'd1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 1, E_NORM);
  endtask

  task automatic frz(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 1, 0, E_HOLD);
  endtask

  task automatic md_cyc(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 1, E_MD);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    id_rs = '0; id_rt = '0; id_uses_rt = 1'b0;
    id_ex_memread = 1'b0; id_ex_rt = '0;
    ex_branch_taken = 1'b0; ex_muldiv_start = 1'b0;
    mem_req = 1'b0; mem_ready = 1'b1;
    exp_stall = '0;
    exp_to = 1'b0;
    sb.push_back('{ctrl: E_NORM, cnt: 16'd0, to: 1'b0});
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    do_reset();
    idle(2);
    // load-use on rs, then on rt, then non-hazards
    step(9, 0, 0, 1, 9, 0, 0, 0, 1, E_LU);
    idle(1);
    step(3, 9, 1, 1, 9, 0, 0, 0, 1, E_LU);
    step(3, 9, 0, 1, 9, 0, 0, 0, 1, E_NORM);
    step(0, 0, 1, 1, 0, 0, 0, 0, 1, E_NORM);
    step(9, 0, 0, 0, 9, 0, 0, 0, 1, E_NORM);
    // branch beats load-use; freeze beats both
    step(9, 0, 0, 1, 9, 1, 0, 0, 1, E_BR);
    step(9, 0, 0, 1, 9, 1, 0, 1, 0, E_HOLD);
    idle(1);
    // muldiv: 8 busy cycles, start and branch ignored while busy
    step(0, 0, 0, 0, 0, 0, 1, 0, 1, E_NORM);
    md_cyc(2);
    step(0, 0, 0, 0, 0, 1, 1, 0, 1, E_MD);
    md_cyc(5);
    idle(2);
    // muldiv with a 3-cycle freeze mid-way; release on last count
    step(0, 0, 0, 0, 0, 0, 1, 0, 1, E_NORM);
    md_cyc(3);
    frz(3);
    md_cyc(4);
    step(0, 0, 0, 0, 0, 0, 0, 1, 1, E_MD);
    idle(2);
    // muldiv start during a freeze is dropped
    step(0, 0, 0, 0, 0, 0, 1, 1, 0, E_HOLD);
    idle(3);
    // memory timeout after 64 consecutive wait cycles
    for (int i = 0; i < 70; i++) begin
      if (i == 64) exp_to = 1'b1;
      frz(1);
    end
    idle(2);
    do_reset();
    idle(2);
    // long freeze saturates the stall counter
    for (int i = 0; i < 65540; i++) begin
      if (i == 64) exp_to = 1'b1;
      frz(1);
    end
    idle(1);
    frz(1);
    idle(2);
    repeat (3) @(negedge clk);
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL drain left=%0d want=0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
